// File: rtl/siphash_msg_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : siphash_msg_feeder_if
// Brief    : Byte-stream, status and SipHash-core command bundle for the feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface siphash_msg_feeder_if;
    logic        start;
    logic        empty;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        busy;
    logic        done;
    logic        core_initalize;
    logic        core_compress;
    logic        core_finalize;
    logic [63:0] core_mi;
    logic        core_ready;
    logic        core_word_valid;

    // System/core side: supplies bytes and core status, consumes commands.
    modport master (
        output start, empty, in_valid, in_data, in_last, core_ready, core_word_valid,
        input  in_ready, busy, done, core_initalize, core_compress, core_finalize, core_mi
    );

    // Feeder side.
    modport slave (
        input  start, empty, in_valid, in_data, in_last, core_ready, core_word_valid,
        output in_ready, busy, done, core_initalize, core_compress, core_finalize, core_mi
    );
endinterface
`default_nettype wire

// File: rtl/siphash_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : siphash_msg_feeder
// Brief    : Packs a byte stream little-endian into 64-bit SipHash blocks,
//            applies final-block length padding and sequences core commands.
// Revision : 1.0 - initial release
// ============================================================================
module siphash_msg_feeder (
    input  wire                  clk,
    input  wire                  reset,
    siphash_msg_feeder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_COLLECT = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT    = 3'd4,
        S_FINAL   = 3'd5,
        S_FWAIT   = 3'd6
    } state_t;

    state_t      r_state;
    logic [63:0] r_blk;
    logic [2:0]  r_idx;
    logic [7:0]  r_len;
    logic        r_last;
    logic        r_pad_pend;
    logic        r_guard;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_init;
    logic        r_comp;
    logic        r_fin;

    logic [7:0]  w_len_next;
    logic [63:0] w_blk_byte;
    logic [63:0] w_keep;
    logic [63:0] w_blk_last;
    logic        w_accept;

    assign w_len_next = r_len + 8'd1;
    assign w_accept   = r_in_ready && bus.in_valid;

    // Final short block: keep bytes 0..idx, zero the rest, length in byte 7.
    always_comb begin
        w_blk_byte = r_blk;
        w_blk_byte[{r_idx, 3'b000} +: 8] = bus.in_data;
        w_keep     = ~(64'hFFFF_FFFF_FFFF_FF00 << {r_idx, 3'b000});
        w_blk_last = {w_len_next, w_blk_byte[55:0] & w_keep[55:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_blk      <= 64'h0;
            r_idx      <= 3'd0;
            r_len      <= 8'd0;
            r_last     <= 1'b0;
            r_pad_pend <= 1'b0;
            r_guard    <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_init     <= 1'b0;
            r_comp     <= 1'b0;
            r_fin      <= 1'b0;
        end else begin
            r_init <= 1'b0;
            r_comp <= 1'b0;
            r_fin  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_blk      <= 64'h0;
                        r_idx      <= 3'd0;
                        r_len      <= 8'd0;
                        r_last     <= bus.empty;
                        r_pad_pend <= 1'b0;
                        r_init     <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (r_last) begin
                        r_state <= S_SEND;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 3'd1;
                        r_len <= w_len_next;
                        if (bus.in_last) begin
                            r_last     <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_state    <= S_SEND;
                            if (r_idx == 3'd7) begin
                                // Full block ends the message: length goes in its own block.
                                r_blk      <= w_blk_byte;
                                r_pad_pend <= 1'b1;
                            end else begin
                                r_blk <= w_blk_last;
                            end
                        end else begin
                            r_blk <= w_blk_byte;
                            if (r_idx == 3'd7) begin
                                r_in_ready <= 1'b0;
                                r_state    <= S_SEND;
                            end
                        end
                    end
                end
                S_SEND: begin
                    if (bus.core_ready) begin
                        r_comp  <= 1'b1;
                        r_guard <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Core ready is stale during the command cycle; skip it.
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (bus.core_ready) begin
                        if (r_pad_pend) begin
                            r_blk      <= {r_len, 56'h0};
                            r_pad_pend <= 1'b0;
                            r_state    <= S_SEND;
                        end else if (r_last) begin
                            r_state <= S_FINAL;
                        end else begin
                            r_blk      <= 64'h0;
                            r_idx      <= 3'd0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_COLLECT;
                        end
                    end
                end
                S_FINAL: begin
                    if (bus.core_ready) begin
                        r_fin   <= 1'b1;
                        r_guard <= 1'b1;
                        r_state <= S_FWAIT;
                    end
                end
                S_FWAIT: begin
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (bus.core_word_valid && bus.core_ready) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.core_initalize = r_init;
    assign bus.core_compress  = r_comp;
    assign bus.core_finalize  = r_fin;
    assign bus.core_mi        = r_blk;

endmodule
`default_nettype wire

// File: tb/tb_siphash_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_siphash_msg_feeder
// Brief    : Self-checking bench for siphash_msg_feeder with a SipHash-2-4 core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_siphash_msg_feeder;

    logic clk;
    logic reset;

    siphash_msg_feeder_if bus ();

    siphash_msg_feeder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  msg_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          fin_cnt   = 0;
    int          proto_err = 0;
    logic [63:0] m_digest  = 64'h0;
    logic        m_ready;
    logic        m_wv;

    assign bus.core_ready      = m_ready;
    assign bus.core_word_valid = m_wv;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    // State packing: {v3, v2, v1, v0}
    function automatic logic [255:0] sipround(input logic [255:0] v);
        logic [63:0] a, b, c, d;
        a = v[63:0]; b = v[127:64]; c = v[191:128]; d = v[255:192];
        a = a + b; b = rotl(b, 13); b = b ^ a; a = rotl(a, 32);
        c = c + d; d = rotl(d, 16); d = d ^ c;
        a = a + d; d = rotl(d, 21); d = d ^ a;
        c = c + b; b = rotl(b, 17); b = b ^ c; c = rotl(c, 32);
        return {d, c, b, a};
    endfunction

    function automatic logic [255:0] sip_init();
        logic [63:0] k0, k1;
        k0 = 64'h0706050403020100;
        k1 = 64'h0f0e0d0c0b0a0908;
        return {k1 ^ 64'h7465646279746573, k0 ^ 64'h6c7967656e657261,
                k1 ^ 64'h646f72616e646f6d, k0 ^ 64'h736f6d6570736575};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: SipHash-2-4 straight from its definition over the byte queue.
    task automatic build_ref(output logic [63:0] dig);
        logic [7:0]   p[$];
        logic [255:0] v;
        logic [63:0]  m;
        p = msg_q;
        while ((p.size() % 8) != 7) p.push_back(8'h00);
        p.push_back(8'(msg_q.size()));
        exp_q.delete();
        v = sip_init();
        for (int b = 0; b < p.size() / 8; b++) begin
            m = 64'h0;
            for (int j = 0; j < 8; j++) m[8*j +: 8] = p[8*b + j];
            exp_q.push_back(m);
            v[255:192] = v[255:192] ^ m;
            v = sipround(sipround(v));
            v[63:0] = v[63:0] ^ m;
        end
        v[191:128] = v[191:128] ^ 64'hff;
        repeat (4) v = sipround(v);
        dig = v[63:0] ^ v[127:64] ^ v[191:128] ^ v[255:192];
    endtask

    // Behavioural core: random busy time after each command, logs blocks and protocol errors.
    initial begin : core_model
        logic [255:0] mv;
        int           ncmd;
        int           lat;
        int           m_lat;
        logic         fin_pend;
        logic         prev_cmd;
        mv = '0; m_lat = 0; fin_pend = 1'b0; prev_cmd = 1'b0;
        m_ready = 1'b1; m_wv = 1'b0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_ready  <= 1'b1;
                m_wv     <= 1'b0;
                m_lat    = 0;
                fin_pend = 1'b0;
                prev_cmd = 1'b0;
            end else begin
                ncmd = int'(bus.core_initalize) + int'(bus.core_compress) + int'(bus.core_finalize);
                if (ncmd > 1 || (ncmd == 1 && (!m_ready || prev_cmd))) proto_err++;
                prev_cmd = (ncmd != 0);
                if (bus.core_initalize) begin
                    mv = sip_init();
                    m_wv <= 1'b0;
                end
                if (bus.core_compress) begin
                    got_q.push_back(bus.core_mi);
                    mv[255:192] = mv[255:192] ^ bus.core_mi;
                    mv = sipround(sipround(mv));
                    mv[63:0] = mv[63:0] ^ bus.core_mi;
                end
                if (bus.core_finalize) begin
                    fin_cnt++;
                    mv[191:128] = mv[191:128] ^ 64'hff;
                    repeat (4) mv = sipround(mv);
                    m_digest = mv[63:0] ^ mv[127:64] ^ mv[191:128] ^ mv[255:192];
                end
                if (ncmd != 0) begin
                    lat      = int'($urandom_range(0, 3));
                    m_lat    = lat;
                    fin_pend = bus.core_finalize;
                    m_ready <= (lat == 0);
                    if (lat == 0 && bus.core_finalize) m_wv <= 1'b1;
                end else if (m_lat > 0) begin
                    m_lat = m_lat - 1;
                    if (m_lat == 0) begin
                        m_ready <= 1'b1;
                        if (fin_pend) m_wv <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({pfx, "_busy"},     64'(bus.busy), 64'd0);
        check({pfx, "_done"},     64'(bus.done), 64'd0);
        check({pfx, "_cmds"},     64'({bus.core_initalize, bus.core_compress, bus.core_finalize}), 64'd0);
        check({pfx, "_core_mi"},  bus.core_mi, 64'd0);
    endtask

    task automatic run_msg(input int n, input bit pattern, input bit bursty, input bit disturb,
                           input bit abort, input bit known, input logic [63:0] known_dig);
        int          base, fin0, perr0, cyc, ir_hi;
        logic [63:0] dig;
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(pattern ? 8'(i) : 8'($urandom));
        build_ref(dig);
        base = got_q.size(); fin0 = fin_cnt; perr0 = proto_err;

        @(negedge clk);
        bus.start = 1'b1;
        bus.empty = (n == 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.empty = 1'b0;
        check("init_pulse", 64'(bus.core_initalize), 64'd1);
        check("busy_rise", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("init_drop", 64'(bus.core_initalize), 64'd0);
        check("in_ready_start", 64'(bus.in_ready), 64'(n != 0));

        for (int i = 0; i < n; i++) begin
            if (abort && i == 8) begin
                cyc = 0;
                while (!bus.core_compress && cyc < 200) begin @(negedge clk); cyc++; end
                check("abort_reach_wait", 64'(bus.core_compress), 64'd1);
                reset = 1'b1;
                #1;
                check_outputs_zero("rst_mid");
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (bursty) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = msg_q[i];
            bus.in_last  = (i == n - 1);
            cyc = 0;
            while (!bus.in_ready && cyc < 500) begin @(negedge clk); cyc++; end
            if (cyc >= 500) begin
                check("accept_timeout", 64'(bus.in_ready), 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (abort && i == 7) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("in_ready_after_last", 64'(bus.in_ready), 64'd0);

        cyc = 0; ir_hi = 0;
        if (disturb) begin
            bus.start    = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
        end
        while (!bus.done && cyc < 3000) begin
            if (bus.in_ready) ir_hi++;
            @(negedge clk);
            cyc++;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("done_seen", 64'(bus.done), 64'd1);
        check("busy_at_done", 64'(bus.busy), 64'd0);
        check("in_ready_quiet", 64'(ir_hi), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("blk_count", 64'(got_q.size() - base), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++)
            check($sformatf("blk%0d", k), got_q[base + k], exp_q[k]);
        check("finalize_count", 64'(fin_cnt - fin0), 64'd1);
        check("protocol", 64'(proto_err - perr0), 64'd0);
        check("digest_ref", m_digest, dig);
        if (known) check("digest_vector", m_digest, known_dig);
    endtask

    initial begin : stim
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.empty    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_msg(15,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'ha129ca6149be45e5);
        run_msg(8,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        run_msg(0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h726fdb47dd0e0e31);
        run_msg(256, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        run_msg(15,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'ha129ca6149be45e5);
        run_msg(15,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        run_msg(15,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'ha129ca6149be45e5);
        for (int r = 0; r < 4; r++)
            run_msg(int'($urandom_range(1, 40)), 1'b0, 1'b1, r[0], 1'b0, 1'b0, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/siphash_msg_feeder.md
# siphash_msg_feeder

Byte-stream front end for the SipHash core. Accepts a message one byte at a time over a valid/ready interface and packs the bytes little-endian into 64-bit words. It applies SipHash final-block padding (message length mod 256 in the top byte) and sequences the core's initalize / compress / finalize command pulses against the core's `ready` and `siphash_word_valid` outputs. Key, c and d are driven to the core by the system, not by this block.

## Interface
- Parameters: none.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new message; sampled only in IDLE.
- `empty`  in  1  qualifies `start`: message has zero bytes.
- `in_valid`  in  1  byte available.
- `in_ready`  out  1  feeder accepts byte this cycle.
- `in_data`  in  8  message byte.
- `in_last`  in  1  byte is the final byte of the message.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the core digest is valid.
- `core_initalize`  out  1  to core `initalize`.
- `core_compress`  out  1  to core `compress`.
- `core_finalize`  out  1  to core `finalize`.
- `core_mi`  out  64  to core `mi`; holds the assembled block.
- `core_ready`  in  1  from core `ready`.
- `core_word_valid`  in  1  from core `siphash_word_valid`.

## Operation
- Registers:
  - `blk_reg[63:0]`: block assembly.
  - `idx_reg[2:0]`: byte position in the block.
  - `len_reg[7:0]`: byte count, wraps mod 256.
  - `last_reg`: message ended.
  - `pad_pend_reg`: a separate pad block is still owed.
- Byte packing: a byte accepted at position i is written to `blk_reg[8i+7:8i]`. Every accepted byte increments `idx_reg` and `len_reg`.
- FSM states:
  - **IDLE**
    - `start`=1 → INIT. Clears `blk_reg`, `idx_reg`, `len_reg`, `last_reg` and `pad_pend_reg`.
    - If `empty`=1, also set `last_reg`.
  - **INIT**
    - `core_initalize`=1 for exactly this cycle.
    - → SEND if `last_reg`. `blk_reg` is then all zeros, so the block is 0x0000000000000000.
    - → COLLECT otherwise.
  - **COLLECT**
    - `in_ready`=1; a byte is accepted when `in_valid`=1.
    - Accepted at position 7 without `in_last` → SEND.
    - Accepted at position 7 with `in_last` → SEND, with `last_reg`=1 and `pad_pend_reg`=1.
    - Accepted at position 0..6 with `in_last` → SEND, with `last_reg`=1. Bytes i+1..6 are set to zero and byte 7 is set to `len_reg`+1 (the updated length) in the same write.
  - **SEND**
    - When `core_ready`=1, `core_compress`=1 for one cycle → WAIT.
    - `core_mi`=`blk_reg` throughout this state.
  - **WAIT**
    - The first cycle is a guard; `core_ready` is ignored.
    - Afterwards, on `core_ready`=1:
      - `pad_pend_reg` set → `blk_reg`={`len_reg`,56'h0}, clear `pad_pend_reg`, → SEND.
      - else `last_reg` set → FINAL.
      - else → clear `blk_reg` and `idx_reg`, → COLLECT.
  - **FINAL**: when `core_ready`=1, `core_finalize`=1 for one cycle → FWAIT.
  - **FWAIT**: the first cycle is a guard. Afterwards, on `core_word_valid`=1 and `core_ready`=1 → `done`=1 for one cycle → IDLE.
- Commands are mutually exclusive: at most one `core_*` command is high in any cycle.
- `start` outside IDLE is ignored.
- `in_valid` outside COLLECT is not accepted; the source holds the byte.
- Length wrap: a 256-byte message yields a final length byte of 0x00.

## Timing
- Reset values:
  - All outputs are 0, including `core_mi`=64'h0.
  - All registers are cleared and the FSM is in IDLE.
- Reset mid-operation takes effect immediately (asynchronous): commands drop and `busy` drops. The core is reset by the same system reset.
- `start` sampled at edge N → `core_initalize` high in cycle N+1 → `in_ready` high from cycle N+2.
- Input throughput in COLLECT is 1 byte/cycle. `in_ready` is 0 from the edge that accepts byte 7 or the last byte until re-entry into COLLECT.
- Every `core_*` output is registered, high for exactly one cycle, and issued only when `core_ready`=1 in that cycle.
- Command-to-next-command spacing is at least 2 cycles (1 command cycle + 1 guard cycle) plus the core's busy time.
- `done` is asserted 1 cycle after `core_word_valid` is seen in FWAIT (past the guard cycle). `busy` falls on the same edge that `done` rises.

## Test plan
- Key 00..0f, c=2, d=4, message 00..0e (15 bytes):
  - Compress blocks are 0x0706050403020100 then 0x0f0e0d0c0b0a0908, then one finalize.
  - `done` pulses; digest low 64 bits = 0xa129ca6149be45e5.
- Same key, 8-byte message 00..07:
  - Compress blocks are 0x0706050403020100 then 0x0800000000000000.
  - `in_ready`=0 from the acceptance of byte 7 until `done`.
- Same key, `start` with `empty`=1:
  - Exactly one compress with 0x0000000000000000, then finalize.
  - Digest = 0x726fdb47dd0e0e31.
- 256-byte message with bursty `in_valid` (random gaps):
  - 33 compress pulses; final block 0x0000000000000000; no byte lost or duplicated.
- `start` pulsed while `busy`=1, and `in_valid`=1 held during SEND/WAIT:
  - Both are ignored; the command sequence and the digest are unchanged.
- `reset` asserted in WAIT:
  - All outputs are 0 immediately.
  - After release, a new 15-byte message (as in the first scenario) completes with the correct digest.
